// File: rtl/bitonic_pkg.sv
// Shared definitions for the pipelined bitonic sorter.
//   DIR_ASC / DIR_DESC : encoding of the per-vector sort direction.
//   num_stages()       : compare-exchange column count for 2**log_n keys.
//   stage_phase()      : phase p (1..log_n) of a column index.
//   stage_step()       : step s (p..1) of a column index.
package bitonic_pkg;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  function automatic int unsigned num_stages(input int unsigned log_n);
    return log_n * (log_n + 1) / 2;
  endfunction

  // Phase p contributes p columns, so walk the phases until the column falls inside one.
  function automatic int unsigned stage_phase(input int unsigned c);
    int unsigned rem;
    int unsigned p;
    rem = c;
    p   = 0;
    for (int unsigned q = 1; q <= 32; q++) begin
      if (p == 0) begin
        if (rem < q) p = q;
        else         rem = rem - q;
      end
    end
    return p;
  endfunction

  // Within phase p the steps run p, p-1, .., 1.
  function automatic int unsigned stage_step(input int unsigned c);
    int unsigned rem;
    int unsigned p;
    rem = c;
    p   = 0;
    for (int unsigned q = 1; q <= 32; q++) begin
      if (p == 0) begin
        if (rem < q) p = q;
        else         rem = rem - q;
      end
    end
    return p - rem;
  endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// Combinational compare-exchange element of the bitonic network.
//   a_i, b_i : keys at the lower / upper network position.
//   dir_i    : DIR_ASC puts the smaller key on lo_o, DIR_DESC the larger.
//   lo_o     : key for the lower position, hi_o : key for the upper position.
// Optional (BITONIC_SORT_TAG_EN): a_tag_i/b_tag_i follow their keys to lo_tag_o/hi_tag_o,
// and equal keys are ordered by tag so the overall sort is stable.
module bitonic_cmp_swap
  import bitonic_pkg::*;
#(
  parameter int unsigned DATA_W = 8
`ifdef BITONIC_SORT_TAG_EN
  ,
  parameter int unsigned TAG_W  = 3
`endif
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              dir_i,
`ifdef BITONIC_SORT_TAG_EN
  input  logic [TAG_W-1:0]  a_tag_i,
  input  logic [TAG_W-1:0]  b_tag_i,
  output logic [TAG_W-1:0]  lo_tag_o,
  output logic [TAG_W-1:0]  hi_tag_o,
`endif
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  logic swap;

`ifdef BITONIC_SORT_TAG_EN
  // Tags are unique, so the {key, tag} composite never ties.
  logic [DATA_W+TAG_W-1:0] key_a, key_b;
  assign key_a = {a_i, a_tag_i};
  assign key_b = {b_i, b_tag_i};
  assign swap  = (dir_i == DIR_DESC) ? (key_a < key_b) : (key_a > key_b);
  assign lo_tag_o = swap ? b_tag_i : a_tag_i;
  assign hi_tag_o = swap ? a_tag_i : b_tag_i;
`else
  // Strict compare: equal keys stay where they are.
  assign swap = (dir_i == DIR_DESC) ? (a_i < b_i) : (a_i > b_i);
`endif

  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorting network for N = 2**LOG_N unsigned keys.
// One register stage follows each compare-exchange column; latency is NUM_STG cycles.
//   clk, reset          : clock and synchronous active-high reset.
//   in_valid/in_ready   : input handshake; in_ready depends only on out_valid/out_ready.
//   in_data, in_desc    : keys (key k at [k*DATA_W +: DATA_W]) and direction (1 = descending).
//   out_valid/out_ready : output handshake; outputs hold while stalled.
//   out_data, out_desc  : sorted keys and the direction that travelled with them.
// Optional macro BITONIC_SORT_TAG_EN adds out_tag (original index of each sorted key,
// LOG_N bits per field) and makes the sort stable by breaking key ties on that index.
module bitonic_sort_pipe
  import bitonic_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG_N  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(2**LOG_N)*DATA_W-1:0]  in_data,
  input  logic                          in_desc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**LOG_N)*DATA_W-1:0]  out_data,
`ifdef BITONIC_SORT_TAG_EN
  output logic [(2**LOG_N)*LOG_N-1:0]   out_tag,
`endif
  output logic                          out_desc
);

  localparam int unsigned N       = 2**LOG_N;
  localparam int unsigned NUM_STG = num_stages(LOG_N);
  localparam int unsigned VEC_W   = N * DATA_W;

  logic stall, accept;

  // Per-column combinational inputs/outputs and the register after each column.
  logic [VEC_W-1:0] col_in   [NUM_STG];
  logic [VEC_W-1:0] col_out  [NUM_STG];
  logic             col_desc [NUM_STG];
  logic [VEC_W-1:0] data_q   [NUM_STG];
  logic             desc_q   [NUM_STG];
  logic             valid_q  [NUM_STG];

`ifdef BITONIC_SORT_TAG_EN
  localparam int unsigned TAG_W = LOG_N;
  localparam int unsigned TVEC_W = N * TAG_W;
  logic [TVEC_W-1:0] tag_init;
  logic [TVEC_W-1:0] tcol_in  [NUM_STG];
  logic [TVEC_W-1:0] tcol_out [NUM_STG];
  logic [TVEC_W-1:0] tag_q    [NUM_STG];

  for (genvar k = 0; k < N; k++) begin : g_tag_init
    assign tag_init[k*TAG_W +: TAG_W] = TAG_W'(k);
  end
`endif

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  for (genvar c = 0; c < NUM_STG; c++) begin : g_col
    localparam int unsigned P = stage_phase(c);
    localparam int unsigned S = stage_step(c);

    if (c == 0) begin : g_first
      assign col_in[c]   = in_data;
      assign col_desc[c] = in_desc;
`ifdef BITONIC_SORT_TAG_EN
      assign tcol_in[c]  = tag_init;
`endif
    end else begin : g_rest
      assign col_in[c]   = data_q[c-1];
      assign col_desc[c] = desc_q[c-1];
`ifdef BITONIC_SORT_TAG_EN
      assign tcol_in[c]  = tag_q[c-1];
`endif
    end

    for (genvar j = 0; j < N / 2; j++) begin : g_pair
      // Lower index of pair j: insert a zero at bit S-1; the partner has that bit set.
      localparam int unsigned I   = ((j >> (S - 1)) << S) | (j & ((1 << (S - 1)) - 1));
      localparam int unsigned J   = I | (1 << (S - 1));
      // Bit P of I is zero in the last phase, leaving in_desc alone in control.
      localparam logic        BIT = 1'((I >> P) & 1);

      bitonic_cmp_swap #(
        .DATA_W (DATA_W)
`ifdef BITONIC_SORT_TAG_EN
        ,
        .TAG_W  (TAG_W)
`endif
      ) u_cmp (
        .a_i      (col_in[c][I*DATA_W +: DATA_W]),
        .b_i      (col_in[c][J*DATA_W +: DATA_W]),
        .dir_i    (col_desc[c] ^ BIT),
`ifdef BITONIC_SORT_TAG_EN
        .a_tag_i  (tcol_in[c][I*TAG_W +: TAG_W]),
        .b_tag_i  (tcol_in[c][J*TAG_W +: TAG_W]),
        .lo_tag_o (tcol_out[c][I*TAG_W +: TAG_W]),
        .hi_tag_o (tcol_out[c][J*TAG_W +: TAG_W]),
`endif
        .lo_o     (col_out[c][I*DATA_W +: DATA_W]),
        .hi_o     (col_out[c][J*DATA_W +: DATA_W])
      );
    end
  end

  // Whole pipe freezes on stall; payload registers load only under a valid
  // entry so empty stages keep quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_STG; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        desc_q[k]  <= 1'b0;
`ifdef BITONIC_SORT_TAG_EN
        tag_q[k]   <= '0;
`endif
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      if (accept) begin
        data_q[0] <= col_out[0];
        desc_q[0] <= col_desc[0];
`ifdef BITONIC_SORT_TAG_EN
        tag_q[0]  <= tcol_out[0];
`endif
      end
      for (int unsigned k = 1; k < NUM_STG; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) begin
          data_q[k] <= col_out[k];
          desc_q[k] <= col_desc[k];
`ifdef BITONIC_SORT_TAG_EN
          tag_q[k]  <= tcol_out[k];
`endif
        end
      end
    end
  end

  assign out_valid = valid_q[NUM_STG-1];
  assign out_data  = data_q[NUM_STG-1];
  assign out_desc  = desc_q[NUM_STG-1];
`ifdef BITONIC_SORT_TAG_EN
  assign out_tag   = tag_q[NUM_STG-1];
`endif

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe at LOG_N=3, DATA_W=8: directed vectors with literal
// expectations plus a queue-based sorting model checked on every output transfer.
module tb_bitonic_sort_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned LN = 3;
  localparam int unsigned N  = 8;
  localparam int unsigned NS = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_desc = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [63:0]   out_data;
  logic          out_desc;
`ifdef BITONIC_SORT_TAG_EN
  logic [23:0]   out_tag;
`endif

  bitonic_sort_pipe #(
    .DATA_W (DW),
    .LOG_N  (LN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BITONIC_SORT_TAG_EN
    .out_tag   (out_tag),
`endif
    .out_desc  (out_desc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        desc;
    logic [23:0] tag;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cyc = 0, acc_cyc = 0, out_cyc = 0, out_cnt = 0, ov_cyc = 0;
  bit acc_now = 0;
  logic prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic prev_desc;
  logic [63:0] last_data;
  logic last_desc;
  logic [23:0] last_tag;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int k[8]);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = k[i][7:0];
    return v;
  endfunction

  function automatic logic [23:0] pt(input int t[8]);
    logic [23:0] v;
    for (int i = 0; i < 8; i++) v[i*3 +: 3] = t[i][2:0];
    return v;
  endfunction

  // Stable insertion sort on (key, original index); descending is its reverse.
  function automatic exp_t model(input logic [63:0] d, input logic desc);
    exp_t e;
    int key[8];
    int idx[8];
    int tk, ti, j;
    for (int i = 0; i < 8; i++) begin
      key[i] = int'(d[i*8 +: 8]);
      idx[i] = i;
    end
    for (int i = 1; i < 8; i++) begin
      tk = key[i]; ti = idx[i]; j = i - 1;
      while (j >= 0 && key[j] > tk) begin
        key[j+1] = key[j]; idx[j+1] = idx[j]; j--;
      end
      key[j+1] = tk; idx[j+1] = ti;
    end
    for (int i = 0; i < 8; i++) begin
      int src;
      src = desc ? 7 - i : i;
      e.data[i*8 +: 8] = key[src][7:0];
      e.tag[i*3 +: 3]  = idx[src][2:0];
    end
    e.desc = desc;
    return e;
  endfunction

  // Runs at the falling edge: everything seen here is what the next rising edge acts on.
  task automatic monitor();
    exp_t e;
    cyc++;
    acc_now = 0;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
      return;
    end
    chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", out_data, prev_data);
      chk("hold_desc", 64'(out_desc), 64'(prev_desc));
    end
    if (out_valid) ov_cyc++;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got vector %h with none pending (cycle %0d)", out_data, cyc);
      end else begin
        e = q.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_desc", 64'(out_desc), 64'(e.desc));
`ifdef BITONIC_SORT_TAG_EN
        chk("sb_tag", 64'(out_tag), 64'(e.tag));
        last_tag = out_tag;
`endif
      end
      last_data = out_data;
      last_desc = out_desc;
      out_cnt++;
      out_cyc = cyc;
    end
    if (in_valid && in_ready) begin
      q.push_back(model(in_data, in_desc));
      acc_now = 1;
      acc_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_desc  = out_desc;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [63:0] d, input logic ds);
    int g;
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = ds;
    g = 0;
    do begin
      tick();
      g++;
    end while (!acc_now && g < 50);
    if (!acc_now) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept after %0d cycles, required accept", g);
    end
    in_valid = 1'b0;
  endtask

  logic [63:0] v_mix, v_asc, v_dsc, v_dup, v_dup_s;
  logic [23:0] t_dup;
  int n0, c0, g;

  initial begin
    v_mix   = pk('{3, 7, 1, 8, 5, 2, 6, 4});
    v_asc   = pk('{1, 2, 3, 4, 5, 6, 7, 8});
    v_dsc   = pk('{8, 7, 6, 5, 4, 3, 2, 1});
    v_dup   = pk('{255, 0, 255, 0, 17, 17, 128, 1});
    v_dup_s = pk('{0, 0, 1, 17, 17, 128, 255, 255});
    t_dup   = pt('{1, 3, 7, 4, 5, 6, 0, 2});

    // Pin the model with hand-computed results.
    chk("model_asc", model(v_mix, 1'b0).data, v_asc);
    chk("model_desc", model(v_mix, 1'b1).data, v_dsc);
    chk("model_dup", model(v_dup, 1'b0).data, v_dup_s);
    chk("model_dup_tag", 64'(model(v_dup, 1'b0).tag), 64'(t_dup));

    // Reset state.
    @(posedge clk); #1;
    ticks(3);
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_desc", 64'(out_desc), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single ascending vector: latency and a one-cycle output pulse.
    ov_cyc = 0;
    send(v_mix, 1'b0);
    ticks(10);
    chk("asc_latency", 64'(out_cyc - acc_cyc), 64'(NS));
    chk("asc_pulse", 64'(ov_cyc), 64'd1);
    chk("asc_data", last_data, v_asc);
    chk("asc_desc", 64'(last_desc), 64'd0);

    // Same keys descending.
    send(v_mix, 1'b1);
    ticks(10);
    chk("desc_data", last_data, v_dsc);
    chk("desc_desc", 64'(last_desc), 64'd1);

    // Eight back-to-back vectors with alternating direction.
    n0 = out_cnt;
    ov_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send(pk('{i, 9 - i, 40, 3 * i, 7, 200 - i, i * i, 100}), 1'(i % 2));
      if (i == 0) c0 = acc_cyc;
    end
    ticks(12);
    chk("b2b_count", 64'(out_cnt - n0), 64'd8);
    chk("b2b_contiguous", 64'(ov_cyc), 64'd8);
    chk("b2b_last_latency", 64'(out_cyc - c0), 64'(NS + 7));

    // Duplicates and extremes.
    send(v_dup, 1'b0);
    ticks(10);
    chk("dup_data", last_data, v_dup_s);
`ifdef BITONIC_SORT_TAG_EN
    chk("dup_tag", 64'(last_tag), 64'(t_dup));
`endif

    // Backpressure with three vectors in flight; a vector offered during the stall is ignored.
    n0 = out_cnt;
    send(pk('{10, 20, 30, 40, 50, 60, 70, 80}), 1'b1);
    send(pk('{9, 9, 9, 1, 1, 1, 5, 5}), 1'b0);
    send(pk('{0, 255, 0, 255, 0, 255, 0, 255}), 1'b1);
    out_ready = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin
      tick();
      g++;
    end
    chk("bp_reached_out", 64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_data  = pk('{1, 2, 3, 4, 5, 6, 7, 8});
    in_desc  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_no_accept", 64'(acc_now), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ticks(12);
    chk("bp_count", 64'(out_cnt - n0), 64'd3);

    // Reset with four vectors in flight: none of them may ever appear.
    for (int i = 0; i < 4; i++) send(pk('{i, 1, 2, 3, 4, 5, 6, 99}), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    n0 = out_cnt;
    ticks(12);
    chk("mid_rst_discard", 64'(out_cnt - n0), 64'd0);
    send(v_mix, 1'b0);
    ticks(10);
    chk("post_rst_data", last_data, v_asc);

    // Random traffic; the monitor checks every transfer against the model.
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || acc_now) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) in_data = in_data & 64'h0303030303030303;
        in_desc  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ticks(20);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
- Parametrised, fully pipelined bitonic sorting network. Successor to the fixed 8-input combinational stage blocks.
- Sorts N = 2**LOG_N unsigned keys of DATA_W bits each.
- Sort direction is selectable per vector.
- Valid/ready handshake on both sides, with backpressure. One vector accepted per cycle when not stalled.
- Sits between the data-capture front end and the result/output formatter.

Parameters:
- DATA_W, 8, width of one key in bits (>=1).
- LOG_N, 3, log2 of the key count; N = 2**LOG_N, legal 1..5.
- NUM_STG, LOG_N*(LOG_N+1)/2, derived local constant: number of compare-exchange columns and pipeline depth. Not overridable.

Ports:
- clk, input, 1, sole clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data/in_desc are valid this cycle.
- in_ready, output, 1, block can accept a vector this cycle.
- in_data, input, N*DATA_W, key k at bits [k*DATA_W +: DATA_W], k = 0..N-1.
- in_desc, input, 1, 0 = ascending (out key 0 smallest), 1 = descending.
- out_valid, output, 1, out_data holds a sorted vector.
- out_ready, input, 1, downstream accepts out_data this cycle.
- out_data, output, N*DATA_W, sorted keys, same packing as in_data.
- out_desc, output, 1, in_desc value that travelled with this vector.

Behaviour:
- Reset (sync, active-high):
  - every stage valid bit = 0, so out_valid = 0.
  - out_data = 0, out_desc = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - reset has priority over every other input in the same cycle. Vectors in flight are discarded, not flushed out.
- Network:
  - standard bitonic network, NUM_STG columns; column c = (phase p, step s), p = 1..LOG_N, s = p..1.
  - element i is partnered with i XOR 2**(s-1).
  - sub-block direction = bit p of i, XOR in_desc; phase LOG_N always uses in_desc alone.
- Pipeline:
  - one register stage after every column. Each stage holds data, desc and valid.
  - latency exactly NUM_STG cycles from an accepted input to out_valid, with no stall (6 cycles for N=8).
- Compare-exchange:
  - unsigned compare; swap only when strictly out of order.
  - equal keys never swap, so behaviour is deterministic.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational from out_valid and out_ready only; no combinational path from in_valid.
  - accept = in_valid & in_ready.
  - on stall, every stage holds its contents; no bubble collapsing.
  - bubbles, i.e. stages with valid = 0, advance normally when not stalled.
- Output:
  - out_valid/out_data/out_desc are held stable while out_valid & ~out_ready.
  - they change only after a transfer (out_valid & out_ready) or reset.
- Throughput: 1 vector per cycle at out_ready = 1 continuously.
- Boundaries:
  - in_valid with in_ready = 0 is ignored. Upstream must hold the vector.
  - simultaneous output transfer and input accept in the same cycle are both legal.
  - LOG_N = 1 reduces to a single compare-exchange with 1-cycle latency.

Optional Feature:
- Macro: BITONIC_SORT_TAG_EN.
- When defined:
  - adds output out_tag, width N*LOG_N. Field k gives the original input index of sorted key k.
  - the tag is carried with each key through the swaps.
  - ties are broken by tag: for equal keys the lower original index goes first in ascending, last in descending. The sort becomes stable, and out_data is unchanged versus tie-free inputs.
- When undefined: no out_tag port, no tag registers, and the tie rule is "never swap equal keys".

Decomposition:
- Package bitonic_pkg:
  - DIR_ASC = 1'b0, DIR_DESC = 1'b1.
  - function num_stages(log_n).
  - functions stage_phase(c) and stage_step(c) mapping a column index to (p, s).
- Sub-module bitonic_cmp_swap:
  - parametrised DATA_W (+ tag width under the macro).
  - inputs a, b, dir; outputs lo/hi ordered per dir.
  - purely combinational; instanced N/2 per column via generate.
- The top level owns all registers and handshake logic.

Test Plan:
- LOG_N=3, in_data keys {3,7,1,8,5,2,6,4}, in_desc=0, out_ready=1 -> 6 cycles later out keys {1,2,3,4,5,6,7,8}, out_desc=0, out_valid high for exactly 1 cycle.
- Same keys, in_desc=1 -> out keys {8,7,6,5,4,3,2,1}, out_desc=1. Then 8 back-to-back vectors alternating direction -> 8 consecutive out_valid cycles, each correctly sorted, in order.
- Duplicates and extremes {255,0,255,0,17,17,128,1}, ascending -> {0,0,1,17,17,128,255,255}. With BITONIC_SORT_TAG_EN -> out_tag {1,3,7,4,5,6,0,2}.
- Backpressure:
  - out_ready low for 5 cycles while 3 vectors are in flight -> out_valid/out_data stable, in_ready=0.
  - after release, all 3 vectors emerge in order; none lost or duplicated.
- Reset mid-stream: assert reset with 4 vectors in flight -> next cycle out_valid=0 and out_data=0; none of the 4 ever appears; a new vector sorts normally.
- Random regression over LOG_N in {1,3,5} and DATA_W in {1,8,16}, with random in_valid and out_ready -> scoreboard sort matches exactly.
